// File: rtl/reconstruct_uv_dec.sv
// ---------------------------------------------------------------------------
// reconstruct_uv_dec
//   Decoder-side chroma macroblock reconstruction. Rebuilds the 8x8 U and V
//   prediction from the latched UV mode and the neighbour pixels, then for
//   each of the 8 chroma 4x4 blocks dequantizes the levels, runs the VP8
//   inverse DCT (vertical pass, horizontal pass), adds the prediction and
//   clips to 0..255.
//
//   Build option: define ZERO_BLOCK_SKIP_EN to let blocks whose nz bit is
//   clear bypass the transform (1 cycle instead of 4). Pixel results are
//   identical with or without it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse, accepted only when idle
//   x, y              macroblock column/row (0 = left/top edge)
//   mode_uv[1:0]      0=DC 1=TM 2=V 3=H (upper bits ignored)
//   levels            block b, coeff n signed 16b at [(b*16+n)*16 +: 16]
//   nz                bit 16+b set = block b has nonzero coefficients
//   q                 dequant factor for coeff n, unsigned 16b at [n*16 +: 16]
//   top_left_u/_v     corner pixels
//   top_u/_v, left_u/_v  neighbour pixel i at [i*8 +: 8]
//   out               pixel (b,r,c) at [(b*16+r*4+c)*8 +: 8]; b0-3 U, b4-7 V
//   busy              high from accepted start until done
//   done              one-cycle pulse, out valid
// ---------------------------------------------------------------------------
module reconstruct_uv_dec #(
  parameter int BLOCK_SIZE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic [31:0]   mode_uv,
  input  logic [2047:0] levels,
  input  logic [31:0]   nz,
  input  logic [255:0]  q,
  input  logic [7:0]    top_left_u,
  input  logic [7:0]    top_left_v,
  input  logic [63:0]   top_u,
  input  logic [63:0]   top_v,
  input  logic [63:0]   left_u,
  input  logic [63:0]   left_v,
  output logic [1023:0] out,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRED  = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] VPASS = 3'd3;
  localparam logic [2:0] HPASS = 3'd4;
  localparam logic [2:0] ADD   = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  // Mode 3 (H) is the fall-through case of the prediction select.
  localparam logic [1:0] MODE_DC = 2'd0;
  localparam logic [1:0] MODE_TM = 2'd1;
  localparam logic [1:0] MODE_V  = 2'd2;

  localparam logic [16:0] K_C1     = 17'd85627;
  localparam logic [16:0] K_C2     = 17'd35468;
  localparam logic [2:0]  LAST_BLK = 3'(BLOCK_SIZE - 1);

  logic [2:0]         state_reg;
  logic [2:0]         b_reg;
  logic [1:0]         mode_reg;
  logic [9:0]         x_reg;
  logic [9:0]         y_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [1023:0]      out_reg;
  logic [7:0]         pred_reg [128];
  // Shared working set: dequantized coefs, then vertical-pass results,
  // then final residuals, one block at a time.
  logic signed [31:0] work_reg [16];

  logic [7:0]         pred_next  [128];
  logic signed [31:0] coef_next  [16];
  logic signed [31:0] vpass_next [16];
  logic signed [31:0] hpass_next [16];
  logic [7:0]         pix_next   [16];
  logic [7:0]         top_px     [2][8];
  logic [7:0]         left_px    [2][8];
  logic [7:0]         tl_px      [2];
  logic [10:0]        sum_top    [2];
  logic [10:0]        sum_left   [2];
  logic [11:0]        dc_sum     [2];
  logic [7:0]         dc_val     [2];
  logic               skip;
  logic               blk_write;
  logic               unused_bits;

`ifdef ZERO_BLOCK_SKIP_EN
  assign skip        = ~nz[{2'b10, b_reg}];
  assign unused_bits = ^{mode_uv[31:2], nz[31:24], nz[15:0]};
`else
  assign skip        = 1'b0;
  assign unused_bits = ^{mode_uv[31:2], nz};
`endif

  // A block is written either from ADD or, when skipped, straight from LOAD.
  assign blk_write = (state_reg == ADD) || ((state_reg == LOAD) && skip);

  // (v*k)>>>16 with a 48-bit product.
  function automatic logic signed [31:0] mul_k(input logic signed [31:0] v,
                                               input logic [16:0] k);
    logic signed [47:0] p;
    p = 48'(v) * $signed({31'b0, k});
    return p[47:16];
  endfunction

  // One 4-point inverse DCT butterfly; returns {o3, o2, o1, o0}.
  function automatic logic [127:0] bfly(input logic signed [31:0] i0, i1, i2, i3);
    logic signed [31:0] a, b, c, d;
    a = i0 + i2;
    b = i0 - i2;
    c = mul_k(i1, K_C2) - mul_k(i3, K_C1);
    d = mul_k(i1, K_C1) + mul_k(i3, K_C2);
    return {a - d, b - c, b + c, a + d};
  endfunction

  assign tl_px[0] = top_left_u;
  assign tl_px[1] = top_left_v;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nb
      assign top_px[0][gi]  = top_u[gi*8 +: 8];
      assign top_px[1][gi]  = top_v[gi*8 +: 8];
      assign left_px[0][gi] = left_u[gi*8 +: 8];
      assign left_px[1][gi] = left_v[gi*8 +: 8];
    end
  endgenerate

  // DC value per plane depends on which edges are available.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      sum_top[p]  = '0;
      sum_left[p] = '0;
      for (int i = 0; i < 8; i++) begin
        sum_top[p]  = sum_top[p] + 11'(top_px[p][i]);
        sum_left[p] = sum_left[p] + 11'(left_px[p][i]);
      end
      if (x_reg != '0 && y_reg != '0)
        dc_sum[p] = (12'(sum_top[p]) + 12'(sum_left[p]) + 12'd8) >> 4;
      else if (y_reg != '0)
        dc_sum[p] = (12'(sum_top[p]) + 12'd4) >> 3;
      else if (x_reg != '0)
        dc_sum[p] = (12'(sum_left[p]) + 12'd4) >> 3;
      else
        dc_sum[p] = 12'd128;
      dc_val[p] = dc_sum[p][7:0];
    end
  end

  generate
    // Prediction pixel gi: plane gi/64, row (gi/8)%8, col gi%8.
    for (gi = 0; gi < 128; gi++) begin : g_pred
      localparam int P = gi / 64;
      localparam int R = (gi / 8) % 8;
      localparam int C = gi % 8;
      logic [10:0] tm_sum;   // two's complement, range -255..510
      logic [7:0]  tm_clip;
      assign tm_sum  = 11'(left_px[P][R]) + 11'(top_px[P][C]) - 11'(tl_px[P]);
      assign tm_clip = tm_sum[10] ? 8'd0 : (|tm_sum[9:8]) ? 8'd255 : tm_sum[7:0];
      assign pred_next[gi] = (mode_reg == MODE_DC) ? dc_val[P] :
                             (mode_reg == MODE_TM) ? tm_clip :
                             (mode_reg == MODE_V)  ? top_px[P][C] : left_px[P][R];
    end

    for (gi = 0; gi < 16; gi++) begin : g_coef
      logic [15:0] lvl;
      logic [47:0] prod;
      assign lvl  = levels[{b_reg, 4'(gi), 4'b0000} +: 16];
      assign prod = {{32{lvl[15]}}, lvl} * {32'b0, q[gi*16 +: 16]};
      assign coef_next[gi] = $signed(prod[31:0]);
    end

    // Index k*4+col: vertical pass runs down column gi, horizontal along row gi.
    for (gi = 0; gi < 4; gi++) begin : g_idct
      logic [127:0] v_bf;
      logic [127:0] h_bf;
      assign v_bf = bfly(work_reg[gi], work_reg[4+gi], work_reg[8+gi], work_reg[12+gi]);
      assign vpass_next[gi]    = $signed(v_bf[31:0]);
      assign vpass_next[4+gi]  = $signed(v_bf[63:32]);
      assign vpass_next[8+gi]  = $signed(v_bf[95:64]);
      assign vpass_next[12+gi] = $signed(v_bf[127:96]);
      // +4 on the DC term gives round-to-nearest on the final >>>3.
      assign h_bf = bfly(work_reg[gi*4] + 32'sd4, work_reg[gi*4+1],
                         work_reg[gi*4+2], work_reg[gi*4+3]);
      assign hpass_next[gi*4]   = $signed(h_bf[31:0])   >>> 3;
      assign hpass_next[gi*4+1] = $signed(h_bf[63:32])  >>> 3;
      assign hpass_next[gi*4+2] = $signed(h_bf[95:64])  >>> 3;
      assign hpass_next[gi*4+3] = $signed(h_bf[127:96]) >>> 3;
    end

    // Block b covers plane b[2], quadrant row b[1], quadrant col b[0].
    for (gi = 0; gi < 16; gi++) begin : g_add
      logic [6:0]         pidx;
      logic signed [31:0] res;
      logic signed [32:0] sum;
      assign pidx = {b_reg[2], b_reg[1], 2'(gi / 4), b_reg[0], 2'(gi % 4)};
      assign res  = (state_reg == ADD) ? work_reg[gi] : 32'sd0;
      assign sum  = 33'(pred_reg[pidx]) + 33'(res);
      assign pix_next[gi] = sum[32] ? 8'd0 : (|sum[31:8]) ? 8'd255 : sum[7:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      b_reg     <= '0;
      mode_reg  <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      out_reg   <= '0;
      for (int i = 0; i < 128; i++) pred_reg[i] <= '0;
      for (int i = 0; i < 16; i++)  work_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          mode_reg  <= mode_uv[1:0];
          x_reg     <= x;
          y_reg     <= y;
          b_reg     <= '0;
          busy_reg  <= 1'b1;
          state_reg <= PRED;
        end
        PRED: begin
          for (int i = 0; i < 128; i++) pred_reg[i] <= pred_next[i];
          state_reg <= LOAD;
        end
        LOAD: if (!skip) begin
          for (int i = 0; i < 16; i++) work_reg[i] <= coef_next[i];
          state_reg <= VPASS;
        end
        VPASS: begin
          for (int i = 0; i < 16; i++) work_reg[i] <= vpass_next[i];
          state_reg <= HPASS;
        end
        HPASS: begin
          for (int i = 0; i < 16; i++) work_reg[i] <= hpass_next[i];
          state_reg <= ADD;
        end
        ADD: ;  // handled by the block write below
        DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (blk_write) begin
        for (int k = 0; k < 16; k++) out_reg[{b_reg, 4'(k), 3'b000} +: 8] <= pix_next[k];
        if (b_reg == LAST_BLK) begin
          state_reg <= DONE;
        end else begin
          b_reg     <= b_reg + 3'd1;
          state_reg <= LOAD;
        end
      end
    end
  end

  assign out  = out_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_reconstruct_uv_dec.sv
// ---------------------------------------------------------------------------
// tb_reconstruct_uv_dec
//   Scoreboard bench for reconstruct_uv_dec. Each launched operation pushes
//   the reference pixels and latency; they are popped when done pulses.
//   Define ZERO_BLOCK_SKIP_EN for both bench and RTL to cover the skip path.
// ---------------------------------------------------------------------------
module tb_reconstruct_uv_dec;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    x, y;
  logic [31:0]   mode_uv;
  logic [2047:0] levels;
  logic [31:0]   nz;
  logic [255:0]  q;
  logic [7:0]    top_left_u, top_left_v;
  logic [63:0]   top_u, top_v, left_u, left_v;
  logic [1023:0] out;
  logic          busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1023:0] pix;
    logic [31:0]   lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  reconstruct_uv_dec dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .mode_uv(mode_uv),
    .levels(levels), .nz(nz), .q(q), .top_left_u(top_left_u), .top_left_v(top_left_v),
    .top_u(top_u), .top_v(top_v), .left_u(left_u), .left_v(left_v),
    .out(out), .busy(busy), .done(done)
  );

  // ---------------- reference model ----------------
  function automatic longint mulk(longint v, longint k);
    return (v * k) >>> 16;
  endfunction

  function automatic int clip8(longint v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  function automatic int lat_model();
    int l;
    l = 2;
    for (int b = 0; b < 8; b++) begin
`ifdef ZERO_BLOCK_SKIP_EN
      l += nz[16+b] ? 4 : 1;
`else
      l += 4;
`endif
    end
    return l;
  endfunction

  function automatic logic [1023:0] model_out();
    logic [1023:0] res;
    int pr[2][8][8];
    res = '0;
    for (int p = 0; p < 2; p++) begin
      int t[8]; int l[8]; int tl; int st; int sl; int dc; int md;
      tl = (p == 0) ? top_left_u : top_left_v;
      st = 0; sl = 0;
      for (int i = 0; i < 8; i++) begin
        t[i] = (p == 0) ? top_u[i*8 +: 8] : top_v[i*8 +: 8];
        l[i] = (p == 0) ? left_u[i*8 +: 8] : left_v[i*8 +: 8];
        st += t[i]; sl += l[i];
      end
      if (x != 0 && y != 0) dc = (st + sl + 8) >> 4;
      else if (y != 0)      dc = (st + 4) >> 3;
      else if (x != 0)      dc = (sl + 4) >> 3;
      else                  dc = 128;
      md = int'(mode_uv[1:0]);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          case (md)
            0: pr[p][r][c] = dc;
            1: pr[p][r][c] = clip8(l[r] + t[c] - tl);
            2: pr[p][r][c] = t[c];
            default: pr[p][r][c] = l[r];
          endcase
    end
    for (int b = 0; b < 8; b++) begin
      longint co[16]; longint tmp[16]; int p; int by; int bx;
      p = b / 4; by = (b % 4) / 2; bx = b % 2;
      for (int n = 0; n < 16; n++) begin
        logic signed [15:0] lv;
        lv = levels[(b*16+n)*16 +: 16];
        co[n] = longint'(lv) * longint'(q[n*16 +: 16]);
      end
      // column pass, results stored column-major as in the reference decoder
      for (int i = 0; i < 4; i++) begin
        longint a, bb, c, d;
        a  = co[i] + co[8+i];
        bb = co[i] - co[8+i];
        c  = mulk(co[4+i], 35468) - mulk(co[12+i], 85627);
        d  = mulk(co[4+i], 85627) + mulk(co[12+i], 35468);
        tmp[i*4+0] = a + d; tmp[i*4+1] = bb + c;
        tmp[i*4+2] = bb - c; tmp[i*4+3] = a - d;
      end
      for (int i = 0; i < 4; i++) begin
        longint dcv, a, bb, c, d, rv[4];
        dcv = tmp[i] + 4;
        a  = dcv + tmp[8+i];
        bb = dcv - tmp[8+i];
        c  = mulk(tmp[4+i], 35468) - mulk(tmp[12+i], 85627);
        d  = mulk(tmp[4+i], 85627) + mulk(tmp[12+i], 35468);
        rv[0] = (a + d) >>> 3; rv[1] = (bb + c) >>> 3;
        rv[2] = (bb - c) >>> 3; rv[3] = (a - d) >>> 3;
        for (int c2 = 0; c2 < 4; c2++)
          res[(b*16+i*4+c2)*8 +: 8] = 8'(clip8(pr[p][by*4+i][bx*4+c2] + rv[c2]));
      end
    end
    return res;
  endfunction

  function automatic int pix(int b, int r, int c);
    return int'(out[(b*16+r*4+c)*8 +: 8]);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    x = '0; y = '0; mode_uv = '0; levels = '0; q = '0;
    nz = 32'hFFFF_0000;
    top_left_u = '0; top_left_v = '0;
    top_u = '0; top_v = '0; left_u = '0; left_v = '0;
  endtask

  task automatic set_level(int b, int n, int v);
    levels[(b*16+n)*16 +: 16] = 16'(v);
  endtask

  task automatic launch(input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    if (push) begin
      e.pix = model_out();
      e.lat = 32'(lat_model());
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got=%h want=0", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    @(negedge clk) rst_n = 1'b1;
    $display("reset: out=0 busy=%b done=%b", busy, done);
  endtask

  task automatic test_mode_v();
    exp_t e; int cyc;
    clear_inputs();
    mode_uv = 32'hFFFF_FFF2;  // upper bits must be ignored
    for (int i = 0; i < 8; i++) begin
      top_u[i*8 +: 8] = 8'(8'h10 + i);
      top_v[i*8 +: 8] = 8'(8'h20 + i);
    end
    launch(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mode_v_busy got=%b want=1", busy); end
    wait_done(cyc);
    e = sb_q.pop_front();
    checks++; if (cyc !== 34) begin errors++; $display("FAIL mode_v_latency got=%0d want=34", cyc); end
    checks++; if (out !== e.pix) begin errors++; $display("FAIL mode_v_out got=%h want=%h", out, e.pix); end
    checks++; if (pix(0,2,1) !== 32'h11) begin errors++; $display("FAIL mode_v_u_pix got=%0h want=11", pix(0,2,1)); end
    checks++; if (pix(5,3,0) !== 32'h24) begin errors++; $display("FAIL mode_v_v_pix got=%0h want=24", pix(5,3,0)); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mode_v_idle got busy=%b done=%b want 0 0", busy, done); end
    $display("op mode_v: latency=%0d", cyc);
  endtask

  task automatic test_dc_level();
    exp_t e; int cyc;
    clear_inputs();
    mode_uv = 32'd0;
    set_level(0, 0, 1);
    q[15:0] = 16'd8;
    launch(1);
    wait_done(cyc);
    e = sb_q.pop_front();
    checks++; if (cyc !== int'(e.lat)) begin errors++; $display("FAIL dc_latency got=%0d want=%0d", cyc, e.lat); end
    checks++; if (out !== e.pix) begin errors++; $display("FAIL dc_out got=%h want=%h", out, e.pix); end
    checks++; if (pix(0,3,3) !== 129) begin errors++; $display("FAIL dc_blk0 got=%0d want=129", pix(0,3,3)); end
    checks++; if (pix(1,0,0) !== 128 || pix(7,2,2) !== 128) begin
      errors++; $display("FAIL dc_other got=%0d,%0d want=128", pix(1,0,0), pix(7,2,2)); end
    $display("op dc_level: latency=%0d blk0=%0d", cyc, pix(0,0,0));
  endtask

  task automatic test_clip();
    exp_t e; int cyc; int want;
    for (int s = 0; s < 2; s++) begin
      clear_inputs();
      mode_uv = 32'd2;
      top_u = {8{8'd250}};
      top_v = {8{8'd250}};
      set_level(0, 0, (s == 0) ? 100 : -100);
      q[15:0] = 16'd8;
      want = (s == 0) ? 255 : 150;
      launch(1);
      wait_done(cyc);
      e = sb_q.pop_front();
      checks++; if (cyc !== int'(e.lat)) begin errors++; $display("FAIL clip_latency got=%0d want=%0d", cyc, e.lat); end
      checks++; if (out !== e.pix) begin errors++; $display("FAIL clip_out got=%h want=%h", out, e.pix); end
      checks++; if (pix(0,1,2) !== want) begin errors++; $display("FAIL clip_pix got=%0d want=%0d", pix(0,1,2), want); end
      $display("op clip sign=%0d: pix=%0d", s, pix(0,1,2));
    end
  endtask

  task automatic test_tm_h();
    exp_t e; int cyc;
    clear_inputs();
    mode_uv = 32'd1;
    top_left_u = 8'd100; top_left_v = 8'd100;
    top_u = {8{8'd120}}; top_v = {8{8'd120}};
    left_u = {8{8'd90}}; left_v = {8{8'd90}};
    launch(1);
    wait_done(cyc);
    e = sb_q.pop_front();
    checks++; if (out !== e.pix) begin errors++; $display("FAIL tm_out got=%h want=%h", out, e.pix); end
    checks++; if (pix(3,1,1) !== 110 || pix(6,0,3) !== 110) begin
      errors++; $display("FAIL tm_pix got=%0d,%0d want=110", pix(3,1,1), pix(6,0,3)); end
    $display("op tm: latency=%0d pix=%0d", cyc, pix(3,1,1));

    clear_inputs();
    mode_uv = 32'd3;
    for (int i = 0; i < 8; i++) left_u[i*8 +: 8] = 8'(i);
    left_v = {8{8'd77}};
    launch(1);
    wait_done(cyc);
    e = sb_q.pop_front();
    checks++; if (out !== e.pix) begin errors++; $display("FAIL h_out got=%h want=%h", out, e.pix); end
    checks++; if (pix(2,1,3) !== 5 || pix(1,3,0) !== 3) begin
      errors++; $display("FAIL h_rows got=%0d,%0d want=5,3", pix(2,1,3), pix(1,3,0)); end
    $display("op h: latency=%0d", cyc);
  endtask

  task automatic test_back_to_back();
    exp_t e; int cyc; int extra;
    clear_inputs();
    mode_uv = 32'd1;
    top_left_u = 8'd30; top_left_v = 8'd200;
    for (int i = 0; i < 8; i++) begin
      top_u[i*8 +: 8] = 8'(40 + 9*i);  left_u[i*8 +: 8] = 8'(250 - 20*i);
      top_v[i*8 +: 8] = 8'(10 + 30*i); left_v[i*8 +: 8] = 8'(5 + 7*i);
    end
    set_level(2, 0, 7); set_level(2, 5, -3); q = {16{16'd12}};
    launch(1);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    start = 1'b1; mode_uv = 32'd0; x = 10'd5; y = 10'd5;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b want=1", busy); end
    wait_done(cyc);
    e = sb_q.pop_front();
    if (cyc > 0) cyc += 6;
    checks++; if (cyc !== int'(e.lat)) begin errors++; $display("FAIL restart_latency got=%0d want=%0d", cyc, e.lat); end
    checks++; if (out !== e.pix) begin errors++; $display("FAIL restart_out got=%h want=%h", out, e.pix); end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL restart_single_done got=%0d extra want=0", extra); end
    $display("op restart_ignored: latency=%0d extra_done=%0d", cyc, extra);
  endtask

  task automatic test_reset_mid();
    exp_t e; int cyc;
    clear_inputs();
    mode_uv = 32'd2;
    top_u = {8{8'd99}};
    launch(0);
    repeat (14) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (out !== '0) begin errors++; $display("FAIL midreset_out got=%h want=0", out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midreset_ctl got busy=%b done=%b want 0 0", busy, done); end
    @(negedge clk) rst_n = 1'b1;
    top_v = {8{8'd33}};
    launch(1);
    wait_done(cyc);
    e = sb_q.pop_front();
    checks++; if (cyc !== int'(e.lat)) begin errors++; $display("FAIL midreset_latency got=%0d want=%0d", cyc, e.lat); end
    checks++; if (out !== e.pix) begin errors++; $display("FAIL midreset_out2 got=%h want=%h", out, e.pix); end
    $display("op reset_mid: rerun latency=%0d", cyc);
  endtask

  task automatic test_random();
    exp_t e; int cyc;
    for (int t = 0; t < 4; t++) begin
      clear_inputs();
      mode_uv = $urandom;
      x = 10'($urandom_range(0, 1)); y = 10'($urandom_range(0, 1));
      top_left_u = 8'($urandom); top_left_v = 8'($urandom);
      top_u = {$urandom, $urandom}; top_v = {$urandom, $urandom};
      left_u = {$urandom, $urandom}; left_v = {$urandom, $urandom};
      for (int n = 0; n < 16; n++) q[n*16 +: 16] = 16'($urandom_range(1, 40));
      nz = '0;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 1) == 1) begin
          nz[16+b] = 1'b1;
          set_level(b, 0, int'($urandom_range(0, 128)) - 64);
          for (int k = 0; k < 2; k++) set_level(b, int'($urandom_range(1, 15)), int'($urandom_range(0, 128)) - 64);
        end
      launch(1);
      wait_done(cyc);
      e = sb_q.pop_front();
      checks++; if (cyc !== int'(e.lat)) begin errors++; $display("FAIL random_latency got=%0d want=%0d", cyc, e.lat); end
      checks++; if (out !== e.pix) begin errors++; $display("FAIL random_out got=%h want=%h", out, e.pix); end
      $display("op random %0d: mode=%0d nz=%02h latency=%0d", t, mode_uv[1:0], nz[23:16], cyc);
    end
  endtask

`ifdef ZERO_BLOCK_SKIP_EN
  task automatic test_skip();
    exp_t e; int cyc;
    for (int s = 0; s < 2; s++) begin
      clear_inputs();
      mode_uv = 32'd0; x = 10'd1; y = 10'd1;
      top_u = {8{8'h40}}; left_u = {8{8'h60}};
      top_v = {8{8'h10}}; left_v = {8{8'h20}};
      nz = (s == 0) ? 32'h0 : 32'h0001_0000;
      if (s == 1) begin set_level(0, 0, 1); q[15:0] = 16'd8; end
      launch(1);
      wait_done(cyc);
      e = sb_q.pop_front();
      checks++; if (cyc !== ((s == 0) ? 10 : 13)) begin
        errors++; $display("FAIL skip_latency got=%0d want=%0d", cyc, (s == 0) ? 10 : 13); end
      checks++; if (out !== e.pix) begin errors++; $display("FAIL skip_out got=%h want=%h", out, e.pix); end
      checks++; if (pix(0,0,0) !== ((s == 0) ? 80 : 81) || pix(4,1,1) !== 24) begin
        errors++; $display("FAIL skip_pix got=%0d,%0d want=%0d,24", pix(0,0,0), pix(4,1,1), (s == 0) ? 80 : 81); end
      $display("op skip %0d: latency=%0d", s, cyc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mode_v();
    test_dc_level();
    test_clip();
    test_tm_h();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef ZERO_BLOCK_SKIP_EN
    test_skip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
